// File: rtl/fazyrv_rf_pkg.sv
// fazyrv_rf_pkg: shared types and helpers for the chunk-serial regfile sequencer
package fazyrv_rf_pkg;
  typedef enum logic [1:0] {IDLE, PRE, SHIFT, DONE} state_e;
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
  } req_t;
  function automatic int nchunks(input int chunksize);
    return 32 / chunksize;
  endfunction
endpackage

// File: rtl/fazyrv_rf_seq.sv
// fazyrv_rf_seq: sequences one full-word chunk-serial register access per request
module fazyrv_rf_seq
  import fazyrv_rf_pkg::*;
#(
  parameter int CHUNKSIZE = 2,
  localparam int NCHUNKS = nchunks(CHUNKSIZE),
  localparam int CW = NCHUNKS > 1 ? $clog2(NCHUNKS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_in,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [4:0]    req_rs1_i,
  input  logic [4:0]    req_rs2_i,
  input  logic [4:0]    req_rd_i,
  input  logic          req_we_i,
  input  logic          abort_i,
  output logic          rf_shft_o,
  output logic [4:0]    rf_rs1_o,
  output logic [4:0]    rf_rs2_o,
  output logic [4:0]    rf_rd_o,
  output logic          rf_we_o,
  output logic          rf_ram_rstb_o,
  output logic          rf_ram_wstb_o,
  output logic [CW-1:0] chunk_o,
  output logic          first_o,
  output logic          last_o,
  output logic          done_o,
  output logic          aborted_o
);
  if (!(CHUNKSIZE == 1 || CHUNKSIZE == 2 || CHUNKSIZE == 4 || CHUNKSIZE == 8)) begin : g_bad_chunksize
    $error("fazyrv_rf_seq: CHUNKSIZE must be 1, 2, 4 or 8");
  end
  state_e        state_q, state_d;
  logic [CW-1:0] chunk_q, chunk_d;
  req_t          req_q, req_d;
  logic          abort_q, abort_d;
  logic          shift, last;
  assign shift = state_q == SHIFT;
  assign last  = shift && chunk_q == CW'(NCHUNKS - 1);
  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    req_d   = req_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        req_d   = req_valid_i ? '{rs1: req_rs1_i, rs2: req_rs2_i, rd: req_rd_i, we: req_we_i && req_rd_i != 5'd0} : req_q;
        state_d = req_valid_i ? PRE : IDLE;
      end
      PRE: begin
        abort_d = abort_q | abort_i;
        chunk_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        abort_d = abort_q | abort_i;
        chunk_d = last ? chunk_q : chunk_q + CW'(1);
        state_d = last ? DONE : SHIFT;
      end
      default: begin
        abort_d = 1'b0;
        chunk_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      chunk_q <= '0;
      req_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      req_q   <= req_d;
      abort_q <= abort_d;
    end
  end
  assign req_ready_o   = state_q == IDLE;
  assign rf_shft_o     = shift;
  assign rf_rs1_o      = req_q.rs1;
  assign rf_rs2_o      = req_q.rs2;
  assign rf_rd_o       = req_q.rd;
  assign rf_we_o       = shift && req_q.we && !abort_q && !abort_i;
  assign rf_ram_wstb_o = rf_we_o;
  assign rf_ram_rstb_o = state_q == PRE || (shift && !last);
  assign chunk_o       = chunk_q;
  assign first_o       = shift && chunk_q == '0;
  assign last_o        = last;
  assign done_o        = state_q == DONE;
  assign aborted_o     = done_o && abort_q;
endmodule

// File: tb/tb_fazyrv_rf_seq.sv
// tb_fazyrv_rf_seq: randomized scoreboard bench over every legal chunk size
module tb_fazyrv_rf_seq;
  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] mask;
    bit          ab;
    int          hs;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int errors = 0;
  bit [3:0] fin = '0;
  function automatic void chk(input int cs, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cs=%0d %s: got %0d expected %0d at %0t", cs, name, act, exp, $time);
    end
  endfunction
  for (genvar g = 0; g < 4; g++) begin : g_cs
    localparam int CS = 1 << g;
    localparam int N = 32 / CS;
    localparam int CW = $clog2(N);
    localparam int RC = N > 5 ? 5 : 2;
    logic rst_n, valid, ready, we, abort, shft, rwe, rstb, wstb, first, last, done, ab;
    logic [4:0] rs1, rs2, rd, o_rs1, o_rs2, o_rd;
    logic [CW-1:0] chunk;
    exp_t q[$];
    exp_t e, m;
    bit rst_test = 1'b0;
    bit rst_done = 1'b0;
    bit force_v = 1'b0;
    int busy_until, abort_cyc, n_hs, c, aa, r, k;
    fazyrv_rf_seq #(.CHUNKSIZE(CS)) dut (
      .clk_i(clk), .rst_in(rst_n), .req_valid_i(valid), .req_ready_o(ready),
      .req_rs1_i(rs1), .req_rs2_i(rs2), .req_rd_i(rd), .req_we_i(we), .abort_i(abort),
      .rf_shft_o(shft), .rf_rs1_o(o_rs1), .rf_rs2_o(o_rs2), .rf_rd_o(o_rd), .rf_we_o(rwe),
      .rf_ram_rstb_o(rstb), .rf_ram_wstb_o(wstb), .chunk_o(chunk), .first_o(first),
      .last_o(last), .done_o(done), .aborted_o(ab)
    );
    always @(negedge clk) begin
      if (rst_n && !rst_test) begin
        if (q.size() != 0 && cyc > q[0].hs) begin
          m = q[0];
          k = cyc - m.hs - 2;
          if (k < 0) chk(CS, "pre_outs", {shft, rstb, rwe, done, ready}, 5'b01000);
          else if (k < N) begin
            chk(CS, "chunk", chunk, k);
            chk(CS, "we", rwe, m.mask[k]);
            chk(CS, "wstb", wstb, m.mask[k]);
            chk(CS, "rstb", rstb, k != N - 1);
            chk(CS, "first_last", {first, last}, {k == 0, k == N - 1});
            chk(CS, "shft_ready_done", {shft, ready, done}, 3'b100);
            chk(CS, "addr", {o_rs1, o_rs2, o_rd}, {m.rs1, m.rs2, m.rd});
          end else begin
            chk(CS, "done_outs", {done, shft, rwe, ready}, 4'b1000);
            chk(CS, "aborted", ab, m.ab);
            chk(CS, "addr_done", {o_rs1, o_rs2, o_rd}, {m.rs1, m.rs2, m.rd});
            void'(q.pop_front());
          end
        end else chk(CS, "idle_outs", {ready, shft, rwe, wstb, rstb, done, ab}, 7'b1000000);
      end
    end
    initial begin
      busy_until = -1;
      abort_cyc = -1;
      n_hs = 0;
      rst_n = 1'b0;
      valid = 1'b0;
      rs1 = '0;
      rs2 = '0;
      rd = '0;
      we = 1'b0;
      abort = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 30 * (N + 4); i++) begin
        @(posedge clk);
        #1;
        c = cyc;
        if (!rst_done && i >= 15 * (N + 4) && c > busy_until) begin
          rst_done = 1'b1;
          rst_test = 1'b1;
          valid = 1'b1;
          rs1 = 5'd1;
          rs2 = 5'd2;
          rd = 5'd9;
          we = 1'b1;
          abort = 1'b0;
          @(posedge clk);
          #1 valid = 1'b0;
          repeat (1 + RC) @(posedge clk);
          #1;
          chk(CS, "chunk_before_rst", chunk, RC);
          rst_n = 1'b0;
          #1;
          chk(CS, "rst_outs", {ready, shft, rwe, rstb, wstb, done, ab, first, last}, 9'b100000000);
          chk(CS, "rst_chunk_addr", {chunk, o_rs1, o_rs2, o_rd}, 0);
          @(posedge clk);
          #1 rst_n = 1'b1;
          busy_until = -1;
          abort_cyc = -1;
          force_v = 1'b1;
          rst_test = 1'b0;
          continue;
        end
        valid = (n_hs < 3 || force_v) ? 1'b1 : 1'($urandom_range(0, 1));
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        we = $urandom_range(0, 3) != 0;
        if (n_hs == 0) {rs1, rs2, rd, we} = {5'd3, 5'd5, 5'd7, 1'b1};
        if (n_hs == 1) {rd, we} = {5'd0, 1'b1};
        if (n_hs == 2) {rd, we} = {5'd12, 1'b1};
        abort = 1'b0;
        if (c == abort_cyc) abort = 1'b1;
        else if (c >= busy_until && n_hs >= 3 && $urandom_range(0, 3) == 0) abort = 1'b1;
        @(negedge clk);
        if (valid && c > busy_until) begin
          r = $urandom_range(0, 3);
          aa = (n_hs < 2) ? N : (n_hs == 2) ? 3 : (r == 0) ? -1 : (r == 1) ? $urandom_range(0, N - 1) : N;
          e.rs1 = rs1;
          e.rs2 = rs2;
          e.rd = rd;
          e.hs = c;
          e.ab = aa < N;
          e.mask = '0;
          for (int j = 0; j < N; j++) e.mask[j] = we && rd != 5'd0 && j < aa;
          q.push_back(e);
          busy_until = c + N + 2;
          abort_cyc = aa < N ? c + 2 + aa : -1;
          n_hs++;
          force_v = 1'b0;
        end
      end
      @(posedge clk);
      #1 valid = 1'b0;
      abort = 1'b0;
      repeat (N + 5) @(posedge clk);
      chk(CS, "drained", q.size(), 0);
      fin[g] = 1'b1;
    end
  end
  initial begin
    int t;
    t = 0;
    while (fin != 4'hf && t < 90000) begin
      @(posedge clk);
      t++;
    end
    if (fin != 4'hf) chk(0, "timeout", fin, 15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
